vector_element_sequencer: RTL and testbench

Iterates element indices for one decoded vector instruction at a time and drives per-cycle register-file read/write selects to the vector execute lanes. Sits directly after the vector decode stage: consumes the control-unit outputs (vs1/vs2/vd, sew, widen/narrow flags, vl, vstart) through a valid/ready handshake. Produces one element group per unstalled cycle until vl is reached, then signals completion.

---
 rtl/vector_element_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_vector_element_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_element_sequencer.sv
// vector_element_sequencer
// Walks the element indices of one decoded vector instruction, NUM_LANES
// elements per unstalled cycle, and presents per-group register selects,
// lane enables and first/last markers to the execute lanes.
module vector_element_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int VLENB     = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 stall,
  input  logic [4:0]           vs1,
  input  logic [4:0]           vs2,
  input  logic [4:0]           vd,
  input  logic [1:0]           sew,
  input  logic                 vd_widen,
  input  logic                 vs2_widen,
  input  logic                 vd_narrow,
  input  logic                 vm,
  input  logic [7:0]           vl,
  input  logic [6:0]           vstart,
  output logic                 ele_valid,
  output logic [7:0]           ele_idx,
  output logic [NUM_LANES-1:0] lane_active,
  output logic [4:0]           vs1_sel,
  output logic [4:0]           vs2_sel,
  output logic [4:0]           vd_sel,
  output logic [3:0]           ele_off,
  output logic                 vm_out,
  output logic                 first,
  output logic                 last,
  output logic                 done,
  output logic                 err
);

  localparam int         LOG2_VLENB = $clog2(VLENB);
  // Clears the low index bits so groups always start lane-aligned.
  localparam logic [7:0] ALIGN_MASK = ~8'(NUM_LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] start_idx_reg;
  logic [4:0] vs1_reg, vs2_reg, vd_reg;
  logic [1:0] sew_reg;
  logic       vd_widen_reg, vs2_widen_reg, vd_narrow_reg, vm_reg;
  logic [7:0] vl_reg;
  logic [6:0] vstart_reg;
  logic       err_reg;

  logic       accept;
  logic       illegal;
  logic       empty;
  logic [7:0] start_aligned;
  logic       run;
  logic       last_grp;
  logic [2:0] vs1_eew, vs2_eew, vd_eew;

  // Register number offset of element idx for an operand whose EEW is 8<<s bits.
  function automatic logic [4:0] reg_offset(input logic [7:0] idx, input logic [2:0] s);
    int sh;
    sh = LOG2_VLENB - int'(s);
    return 5'(idx >> sh);
  endfunction

  assign in_ready      = (state_reg == IDLE) && !flush;
  assign accept        = in_valid && in_ready;
  assign illegal       = (sew == 2'b11) ||
                         ((sew == 2'b10) && (vd_widen || vs2_widen || vd_narrow));
  assign empty         = (vl <= {1'b0, vstart});
  assign start_aligned = {1'b0, vstart} & ALIGN_MASK;
  assign run           = (state_reg == RUN);
  assign last_grp      = run && (({1'b0, idx_reg} + 9'(NUM_LANES)) >= {1'b0, vl_reg});

  // State and index register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      idx_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Capture the instruction fields at accept time.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      start_idx_reg <= 8'd0;
      vs1_reg       <= 5'd0;
      vs2_reg       <= 5'd0;
      vd_reg        <= 5'd0;
      sew_reg       <= 2'd0;
      vd_widen_reg  <= 1'b0;
      vs2_widen_reg <= 1'b0;
      vd_narrow_reg <= 1'b0;
      vm_reg        <= 1'b0;
      vl_reg        <= 8'd0;
      vstart_reg    <= 7'd0;
      err_reg       <= 1'b0;
    end else if (accept) begin
      start_idx_reg <= start_aligned;
      vs1_reg       <= vs1;
      vs2_reg       <= vs2;
      vd_reg        <= vd;
      sew_reg       <= sew;
      vd_widen_reg  <= vd_widen;
      vs2_widen_reg <= vs2_widen;
      vd_narrow_reg <= vd_narrow;
      vm_reg        <= vm;
      vl_reg        <= vl;
      vstart_reg    <= vstart;
      err_reg       <= illegal;
    end
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            idx_next   = start_aligned;
            state_next = (illegal || empty) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (last_grp) state_next = DONE;
            else          idx_next   = idx_reg + 8'(NUM_LANES);
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Effective EEW per operand: widening/narrowing doubles the element size.
  assign vs1_eew = {1'b0, sew_reg};
  assign vs2_eew = {1'b0, sew_reg} + {2'b0, (vs2_widen_reg || vd_narrow_reg)};
  assign vd_eew  = {1'b0, sew_reg} + {2'b0, vd_widen_reg};

  // Per-lane enable: element must lie in [vstart, vl).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [8:0] lane_idx;
      assign lane_idx        = {1'b0, idx_reg} + 9'(gi);
      assign lane_active[gi] = run && (lane_idx >= {2'b0, vstart_reg}) &&
                               (lane_idx < {1'b0, vl_reg});
    end
  endgenerate

  // Group outputs, zero outside RUN; all derived from registered state only.
  always_comb begin
    logic [7:0] off_mask;
    int         sh0;
    sh0       = LOG2_VLENB - int'(sew_reg);
    off_mask  = (8'd1 << sh0) - 8'd1;
    ele_valid = run;
    ele_idx   = 8'd0;
    vs1_sel   = 5'd0;
    vs2_sel   = 5'd0;
    vd_sel    = 5'd0;
    ele_off   = 4'd0;
    first     = 1'b0;
    if (run) begin
      ele_idx = idx_reg;
      vs1_sel = vs1_reg + reg_offset(idx_reg, vs1_eew);
      vs2_sel = vs2_reg + reg_offset(idx_reg, vs2_eew);
      vd_sel  = vd_reg + reg_offset(idx_reg, vd_eew);
      ele_off = 4'(idx_reg & off_mask);
      first   = (idx_reg == start_idx_reg);
    end
  end

  assign last   = last_grp;
  assign vm_out = vm_reg;
  assign done   = (state_reg == DONE);
  assign err    = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Directed bench for vector_element_sequencer (NUM_LANES=2, VLENB=16).
module tb_vector_element_sequencer;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       stall = 1'b0;
  logic [4:0] vs1 = '0, vs2 = '0, vd = '0;
  logic [1:0] sew = '0;
  logic       vd_widen = 1'b0, vs2_widen = 1'b0, vd_narrow = 1'b0, vm = 1'b0;
  logic [7:0] vl = '0;
  logic [6:0] vstart = '0;
  logic       ele_valid;
  logic [7:0] ele_idx;
  logic [1:0] lane_active;
  logic [4:0] vs1_sel, vs2_sel, vd_sel;
  logic [3:0] ele_off;
  logic       vm_out, first, last, done, err;

  vector_element_sequencer #(.NUM_LANES(2), .VLENB(16)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .stall(stall), .vs1(vs1), .vs2(vs2), .vd(vd), .sew(sew),
    .vd_widen(vd_widen), .vs2_widen(vs2_widen), .vd_narrow(vd_narrow), .vm(vm),
    .vl(vl), .vstart(vstart), .ele_valid(ele_valid), .ele_idx(ele_idx),
    .lane_active(lane_active), .vs1_sel(vs1_sel), .vs2_sel(vs2_sel),
    .vd_sel(vd_sel), .ele_off(ele_off), .vm_out(vm_out), .first(first),
    .last(last), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] idx;
    logic [1:0] la;
    logic [4:0] s1, s2, d;
    logic [3:0] off;
    logic       fst, lst;
  } grp_t;

  typedef struct {
    logic [4:0] vs1, vs2, vd;
    logic [1:0] sew;
    logic       vdw, vs2w, vdn, vm;
    logic [7:0] vl;
    logic [6:0] vstart;
    logic       err;
    int         base;
    int         ngrp;
  } ins_t;

  grp_t gt[24];
  ins_t it[9];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic grp_t mkg(int idx, int la, int s1, int s2, int d, int off, int fst, int lst);
    grp_t g;
    g.idx = 8'(idx); g.la = 2'(la); g.s1 = 5'(s1); g.s2 = 5'(s2); g.d = 5'(d);
    g.off = 4'(off); g.fst = 1'(fst); g.lst = 1'(lst);
    return g;
  endfunction

  function automatic ins_t mki(int v1, int v2, int vdd, int s, int vdw, int vs2w, int vdn,
                               int m, int len, int st, int e, int base, int ngrp);
    ins_t x;
    x.vs1 = 5'(v1); x.vs2 = 5'(v2); x.vd = 5'(vdd); x.sew = 2'(s);
    x.vdw = 1'(vdw); x.vs2w = 1'(vs2w); x.vdn = 1'(vdn); x.vm = 1'(m);
    x.vl = 8'(len); x.vstart = 7'(st); x.err = 1'(e); x.base = base; x.ngrp = ngrp;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input ins_t x);
    vs1 = x.vs1; vs2 = x.vs2; vd = x.vd; sew = x.sew;
    vd_widen = x.vdw; vs2_widen = x.vs2w; vd_narrow = x.vdn; vm = x.vm;
    vl = x.vl; vstart = x.vstart;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({name, " ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_grp(input string name, input int gi, input logic m);
    chk({name, " valid"}, 32'(ele_valid), 32'd1);
    chk({name, " idx"}, 32'(ele_idx), 32'(gt[gi].idx));
    chk({name, " lanes"}, 32'(lane_active), 32'(gt[gi].la));
    chk({name, " vs1_sel"}, 32'(vs1_sel), 32'(gt[gi].s1));
    chk({name, " vs2_sel"}, 32'(vs2_sel), 32'(gt[gi].s2));
    chk({name, " vd_sel"}, 32'(vd_sel), 32'(gt[gi].d));
    chk({name, " ele_off"}, 32'(ele_off), 32'(gt[gi].off));
    chk({name, " first"}, 32'(first), 32'(gt[gi].fst));
    chk({name, " last"}, 32'(last), 32'(gt[gi].lst));
    chk({name, " vm_out"}, 32'(vm_out), 32'(m));
    chk({name, " done"}, 32'(done), 32'd0);
  endtask

  // Issue instruction k and follow it through every group and the done cycle.
  task automatic run_instr(input int k);
    string nm;
    nm = $sformatf("ins%0d", k);
    wait_ready(nm);
    load(it[k]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int g = 0; g < it[k].ngrp; g++) begin
      chk_grp($sformatf("ins%0d g%0d", k, g), it[k].base + g, it[k].vm);
      step();
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " err"}, 32'(err), 32'(it[k].err));
    chk({nm, " valid_in_done"}, 32'(ele_valid), 32'd0);
    chk({nm, " ready_in_done"}, 32'(in_ready), 32'd0);
    step();
    chk({nm, " done_clear"}, 32'(done), 32'd0);
    chk({nm, " ready_after"}, 32'(in_ready), 32'd1);
    $display("[TB] instr %0d: vl=%0d vstart=%0d sew=%0d groups=%0d err=%0d",
             k, it[k].vl, it[k].vstart, it[k].sew, it[k].ngrp, it[k].err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // sew=8, vl=5, vstart=0
    gt[0]  = mkg(0, 3, 1, 2, 8, 0, 1, 0);
    gt[1]  = mkg(2, 3, 1, 2, 8, 2, 0, 0);
    gt[2]  = mkg(4, 1, 1, 2, 8, 4, 0, 1);
    // sew=32, vl=12: 4 elements per register
    gt[3]  = mkg(0,  3, 6, 10, 4, 0, 1, 0);
    gt[4]  = mkg(2,  3, 6, 10, 4, 2, 0, 0);
    gt[5]  = mkg(4,  3, 7, 11, 5, 0, 0, 0);
    gt[6]  = mkg(6,  3, 7, 11, 5, 2, 0, 0);
    gt[7]  = mkg(8,  3, 8, 12, 6, 0, 0, 0);
    gt[8]  = mkg(10, 3, 8, 12, 6, 2, 0, 1);
    // sew=16 widening vd from 30: vd wraps past 31
    gt[9]  = mkg(0,  3, 3, 20, 30, 0, 1, 0);
    gt[10] = mkg(2,  3, 3, 20, 30, 2, 0, 0);
    gt[11] = mkg(4,  3, 3, 20, 31, 4, 0, 0);
    gt[12] = mkg(6,  3, 3, 20, 31, 6, 0, 0);
    gt[13] = mkg(8,  3, 4, 21, 0,  0, 0, 0);
    gt[14] = mkg(10, 3, 4, 21, 0,  2, 0, 0);
    gt[15] = mkg(12, 3, 4, 21, 1,  4, 0, 0);
    gt[16] = mkg(14, 3, 4, 21, 1,  6, 0, 1);
    // vstart=3, vl=6: aligned start 2, lane 0 masked on first group
    gt[17] = mkg(2, 2, 7, 9, 5, 2, 1, 0);
    gt[18] = mkg(4, 3, 7, 9, 5, 4, 0, 1);
    // sew=16 narrowing: vs2 at 32b steps every 4
    gt[19] = mkg(0, 3, 3, 2, 4, 0, 1, 0);
    gt[20] = mkg(2, 3, 3, 2, 4, 2, 0, 0);
    gt[21] = mkg(4, 3, 3, 3, 4, 4, 0, 0);
    gt[22] = mkg(6, 3, 3, 3, 4, 6, 0, 0);
    gt[23] = mkg(8, 3, 4, 4, 5, 0, 0, 1);

    //          vs1 vs2 vd sew vdw vs2w vdn vm  vl vst err base n
    it[0] = mki(1,  2,  8, 0,  0,  0,   0,  1,  5, 0,  0,  0,  3);
    it[1] = mki(6,  10, 4, 2,  0,  0,   0,  0, 12, 0,  0,  3,  6);
    it[2] = mki(3,  20, 30,1,  1,  0,   0,  1, 16, 0,  0,  9,  8);
    it[3] = mki(7,  9,  5, 0,  0,  0,   0,  0,  6, 3,  0, 17,  2);
    it[4] = mki(3,  2,  4, 1,  0,  0,   1,  1, 10, 0,  0, 19,  5);
    it[5] = mki(1,  1,  1, 0,  0,  0,   0,  1,  0, 0,  0,  0,  0);
    it[6] = mki(1,  1,  1, 0,  0,  0,   0,  0,  5, 5,  0,  0,  0);
    it[7] = mki(1,  1,  1, 2,  1,  0,   0,  1,  8, 0,  1,  0,  0);
    it[8] = mki(1,  1,  1, 3,  0,  0,   0,  0,  8, 0,  1,  0,  0);

    // Reset state.
    repeat (2) step();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst ele_valid", 32'(ele_valid), 32'd0);
    chk("rst lanes", 32'(lane_active), 32'd0);
    chk("rst vd_sel", 32'(vd_sel), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst vm_out", 32'(vm_out), 32'd0);
    nRST = 1'b1;
    step();

    for (int k = 0; k < 9; k++) run_instr(k);

    // Stall held three cycles on idx 2.
    wait_ready("stall");
    load(it[0]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_grp("stall g0", 0, 1'b1);
    step();
    stall = 1'b1;
    chk_grp("stall c0", 1, 1'b1);
    for (int c = 1; c < 3; c++) begin
      step();
      chk_grp($sformatf("stall c%0d", c), 1, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_grp("stall release", 2, 1'b1);
    step();
    chk("stall done", 32'(done), 32'd1);
    step();
    $display("[TB] stall sequence complete");

    // Flush in the middle of RUN: no done, back to IDLE.
    wait_ready("flush");
    load(it[1]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk_grp("flush pre", 4, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush ready_masked", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush valid", 32'(ele_valid), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush ready", 32'(in_ready), 32'd1);
    step();
    chk("flush done_later", 32'(done), 32'd0);
    $display("[TB] flush mid-run sequence complete");

    // Flush in IDLE blocks acceptance of a valid instruction.
    load(it[0]);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("idle_flush ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("idle_flush valid", 32'(ele_valid), 32'd0);
    chk("idle_flush done", 32'(done), 32'd0);
    $display("[TB] flush in idle sequence complete");

    // Asynchronous reset in the middle of RUN.
    wait_ready("arst");
    load(it[2]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk_grp("arst pre", 11, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst valid", 32'(ele_valid), 32'd0);
    chk("arst idx", 32'(ele_idx), 32'd0);
    chk("arst lanes", 32'(lane_active), 32'd0);
    chk("arst vd_sel", 32'(vd_sel), 32'd0);
    chk("arst vs2_sel", 32'(vs2_sel), 32'd0);
    chk("arst first_last", 32'({first, last}), 32'd0);
    chk("arst vm_out", 32'(vm_out), 32'd0);
    chk("arst ready", 32'(in_ready), 32'd1);
    step();
    nRST = 1'b1;
    step();
    chk("arst post valid", 32'(ele_valid), 32'd0);
    $display("[TB] async reset sequence complete");

    run_instr(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
